// File: rtl/matrix_pkg.sv
// Shared definitions for the compute-mode matrix engine.
//   OP_*       : operation encodings carried on the 3-bit op bus
//   ERR_*      : 4-bit completion codes reported with done
//   state_e    : engine sequencing states
//   mac_mode_e : MAC datapath operation select
package matrix_pkg;

   localparam int unsigned MAX_POSSIBLE_DIM = 5;

   localparam logic [2:0] OP_ADD        = 3'd0;
   localparam logic [2:0] OP_SUB        = 3'd1;
   localparam logic [2:0] OP_MUL        = 3'd2;
   localparam logic [2:0] OP_TRANSPOSE  = 3'd3;
   localparam logic [2:0] OP_SCALAR_MUL = 3'd4;

   localparam logic [3:0] ERR_NONE         = 4'd0;
   localparam logic [3:0] ERR_DIM_MISMATCH = 4'd1;
   localparam logic [3:0] ERR_INVALID_OP   = 4'd2;
   localparam logic [3:0] ERR_DIM_INVALID  = 4'd3;

   typedef enum logic [2:0] {
      StIdle, StCheck, StRdA, StRdB, StAcc, StWr, StDone
   } state_e;

   typedef enum logic [1:0] {
      MacAdd, MacSub, MacMul, MacPass
   } mac_mode_e;

endpackage

// File: rtl/matrix_mac_sat.sv
// Signed accumulator with a combinational saturate/truncate result.
//   clk, rst_n : clock, async active-low reset (acc cleared)
//   en         : update acc this cycle
//   clear      : start from zero instead of the held acc
//   mode       : a+b, a-b, a*b or a passed through
//   a, b       : signed element operands
//   result     : acc clamped to the element range (or truncated)
module matrix_mac_sat
   import matrix_pkg::*;
#(
   parameter int unsigned ELEMENT_WIDTH = 8,
   parameter int unsigned ACC_WIDTH     = 2 * ELEMENT_WIDTH + 4,
   parameter bit          SATURATE      = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic                            clear,
   input  mac_mode_e                       mode,
   input  logic signed [ELEMENT_WIDTH-1:0] a,
   input  logic signed [ELEMENT_WIDTH-1:0] b,
   output logic        [ELEMENT_WIDTH-1:0] result
);

   localparam int unsigned EW = ELEMENT_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH - EW + 1){1'b0}},
                                                     {(EW - 1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, a_ext, b_ext, prod_ext, term;
   logic signed [2*EW-1:0]      prod;

   assign a_ext    = {{(ACC_WIDTH - EW){a[EW-1]}}, a};
   assign b_ext    = {{(ACC_WIDTH - EW){b[EW-1]}}, b};
   assign prod     = a * b;
   assign prod_ext = {{(ACC_WIDTH - 2 * EW){prod[2*EW-1]}}, prod};

   always_comb begin
      term = a_ext;
      case (mode)
         MacAdd:  term = a_ext + b_ext;
         MacSub:  term = a_ext - b_ext;
         MacMul:  term = prod_ext;
         default: term = a_ext;
      endcase
      acc_d = (clear ? '0 : acc_q) + term;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  acc_q <= '0;
      else if (en) acc_q <= acc_d;
   end

   always_comb begin
      if (SATURATE && (acc_q > SAT_MAX))      result = SAT_MAX[EW-1:0];
      else if (SATURATE && (acc_q < SAT_MIN)) result = SAT_MIN[EW-1:0];
      else                                    result = acc_q[EW-1:0];
   end

endmodule

// File: rtl/matrix_compute_engine.sv
// Multi-cycle matrix ALU: streams operands from BRAM over one read port, accumulates
// in a signed MAC and writes the saturated result row-major to dst_addr.
//   clk, rst_n                 : clock, async active-low reset
//   start, abort               : request (sampled in idle), cancel
//   op, a_addr, b_addr, dims   : operation and operand descriptors
//   scalar, dst_addr           : SCALAR multiplier, result base
//   busy, done, error_code     : status; error_code held until next start
//   res_m, res_n               : result dims, valid with done on success
//   mem_rd_*/mem_wr_*          : BRAM ports (read data one cycle after mem_rd_en)
module matrix_compute_engine
   import matrix_pkg::*;
#(
   parameter int unsigned ELEMENT_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH    = 10,
   parameter int unsigned MAX_DIM       = MAX_POSSIBLE_DIM,
   parameter int unsigned ACC_WIDTH     = 2 * ELEMENT_WIDTH + 4,
   parameter bit          SATURATE      = 1'b1,
   localparam int unsigned DIM_W        = $clog2(MAX_DIM + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [2:0]               op,
   input  logic [ADDR_WIDTH-1:0]    a_addr,
   input  logic [ADDR_WIDTH-1:0]    b_addr,
   input  logic [DIM_W-1:0]         a_m,
   input  logic [DIM_W-1:0]         a_n,
   input  logic [DIM_W-1:0]         b_m,
   input  logic [DIM_W-1:0]         b_n,
   input  logic [ELEMENT_WIDTH-1:0] scalar,
   input  logic [ADDR_WIDTH-1:0]    dst_addr,
   output logic                     busy,
   output logic                     done,
   output logic [3:0]               error_code,
   output logic [DIM_W-1:0]         res_m,
   output logic [DIM_W-1:0]         res_n,
   output logic                     mem_rd_en,
   output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
   input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
   output logic                     mem_wr_en,
   output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
   output logic [ELEMENT_WIDTH-1:0] mem_wr_data
);

   state_e                   state_q, state_d;
   logic [2:0]               op_q;
   logic [ADDR_WIDTH-1:0]    a_addr_q, b_addr_q, dst_addr_q;
   logic [DIM_W-1:0]         a_m_q, a_n_q, b_m_q, b_n_q;
   logic [ELEMENT_WIDTH-1:0] scalar_q, a_q;
   logic [DIM_W-1:0]         r_q, c_q, k_q, res_m_q, res_n_q;
   logic [3:0]               err_q;

   logic                     accept, is_mul, is_binary, last_k, last_col, last_row, rd_sel_b;
   logic [3:0]               check_err;
   logic [DIM_W-1:0]         tgt_m, tgt_n;
   logic [ADDR_WIDTH-1:0]    r_w, c_w, k_w, an_w, bn_w, tn_w, a_off, b_off, d_off;
   mac_mode_e                mac_mode;
   logic [ELEMENT_WIDTH-1:0] mac_b, mac_result;

   function automatic logic dim_bad(input logic [DIM_W-1:0] d);
      return (d == '0) || (d > DIM_W'(MAX_DIM));
   endfunction

   // abort beats a coincident start
   assign accept    = (state_q == StIdle) && start && !abort;
   assign is_mul    = (op_q == OP_MUL);
   assign is_binary = (op_q == OP_ADD) || (op_q == OP_SUB) || is_mul;
   assign tgt_m     = (op_q == OP_TRANSPOSE) ? a_n_q : a_m_q;
   assign tgt_n     = is_mul ? b_n_q : (op_q == OP_TRANSPOSE) ? a_m_q : a_n_q;
   assign last_k    = !is_mul || (k_q == a_n_q - DIM_W'(1));
   assign last_col  = (c_q == tgt_n - DIM_W'(1));
   assign last_row  = (r_q == tgt_m - DIM_W'(1));

   always_comb begin
      if (op_q > OP_SCALAR_MUL) begin
         check_err = ERR_INVALID_OP;
      end else if (dim_bad(a_m_q) || dim_bad(a_n_q) ||
                   (is_binary && (dim_bad(b_m_q) || dim_bad(b_n_q)))) begin
         check_err = ERR_DIM_INVALID;
      end else if (((op_q == OP_ADD) || (op_q == OP_SUB)) &&
                   ((a_m_q != b_m_q) || (a_n_q != b_n_q))) begin
         check_err = ERR_DIM_MISMATCH;
      end else if (is_mul && (a_n_q != b_m_q)) begin
         check_err = ERR_DIM_MISMATCH;
      end else begin
         check_err = ERR_NONE;
      end
   end

   // Address generation; (r, c) walks the result, k the MUL inner dimension
   assign r_w  = ADDR_WIDTH'(r_q);
   assign c_w  = ADDR_WIDTH'(c_q);
   assign k_w  = ADDR_WIDTH'(k_q);
   assign an_w = ADDR_WIDTH'(a_n_q);
   assign bn_w = ADDR_WIDTH'(b_n_q);
   assign tn_w = ADDR_WIDTH'(tgt_n);

   always_comb begin
      if (op_q == OP_TRANSPOSE) a_off = c_w * an_w + r_w;
      else if (is_mul)          a_off = r_w * an_w + k_w;
      else                      a_off = r_w * an_w + c_w;
   end

   assign b_off = is_mul ? (k_w * bn_w + c_w) : (r_w * bn_w + c_w);
   assign d_off = r_w * tn_w + c_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      busy      = (state_q != StIdle);
      done      = 1'b0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      rd_sel_b  = 1'b0;
      unique case (state_q)
         StIdle:  if (accept) state_d = StCheck;
         StCheck: state_d = (check_err != ERR_NONE) ? StDone : StRdA;
         StRdA: begin
            mem_rd_en = 1'b1;
            state_d   = StRdB;
         end
         StRdB: begin
            mem_rd_en = is_binary;
            rd_sel_b  = 1'b1;
            state_d   = StAcc;
         end
         StAcc:   state_d = last_k ? StWr : StRdA;
         StWr: begin
            mem_wr_en = 1'b1;
            state_d   = (last_col && last_row) ? StDone : StRdA;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (abort && (state_q != StIdle)) state_d = StIdle;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= '0;
         a_addr_q   <= '0;
         b_addr_q   <= '0;
         dst_addr_q <= '0;
         a_m_q      <= '0;
         a_n_q      <= '0;
         b_m_q      <= '0;
         b_n_q      <= '0;
         scalar_q   <= '0;
         a_q        <= '0;
         r_q        <= '0;
         c_q        <= '0;
         k_q        <= '0;
         res_m_q    <= '0;
         res_n_q    <= '0;
         err_q      <= ERR_NONE;
      end else begin
         if (accept) begin
            op_q       <= op;
            a_addr_q   <= a_addr;
            b_addr_q   <= b_addr;
            dst_addr_q <= dst_addr;
            a_m_q      <= a_m;
            a_n_q      <= a_n;
            b_m_q      <= b_m;
            b_n_q      <= b_n;
            scalar_q   <= scalar;
            err_q      <= ERR_NONE;
         end
         if (state_q == StCheck) begin
            err_q <= check_err;
            r_q   <= '0;
            c_q   <= '0;
            k_q   <= '0;
            if (check_err == ERR_NONE) begin
               res_m_q <= tgt_m;
               res_n_q <= tgt_n;
            end
         end
         if (state_q == StRdB) a_q <= mem_rd_data;
         if (state_q == StAcc) k_q <= last_k ? '0 : k_q + DIM_W'(1);
         if (state_q == StWr) begin
            if (last_col) begin
               c_q <= '0;
               r_q <= r_q + DIM_W'(1);
            end else begin
               c_q <= c_q + DIM_W'(1);
            end
         end
      end
   end

   always_comb begin
      case (op_q)
         OP_ADD:                 mac_mode = MacAdd;
         OP_SUB:                 mac_mode = MacSub;
         OP_MUL, OP_SCALAR_MUL:  mac_mode = MacMul;
         default:                mac_mode = MacPass;
      endcase
   end

   // Binary ops take B straight off the read port in ACC; SCALAR uses the latched multiplier
   assign mac_b = (op_q == OP_SCALAR_MUL) ? scalar_q : mem_rd_data;

   matrix_mac_sat #(
      .ELEMENT_WIDTH (ELEMENT_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH),
      .SATURATE      (SATURATE)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (state_q == StAcc),
      .clear  (k_q == '0),
      .mode   (mac_mode),
      .a      (a_q),
      .b      (mac_b),
      .result (mac_result)
   );

   assign mem_rd_addr = !mem_rd_en ? '0 : rd_sel_b ? (b_addr_q + b_off) : (a_addr_q + a_off);
   assign mem_wr_addr = mem_wr_en ? (dst_addr_q + d_off) : '0;
   assign mem_wr_data = mem_wr_en ? mac_result : '0;
   assign error_code  = err_q;
   assign res_m       = res_m_q;
   assign res_n       = res_n_q;

endmodule

// File: tb/tb_matrix_compute_engine.sv
// Directed bench for matrix_compute_engine with a 1-cycle-latency BRAM model.
module tb_matrix_compute_engine;

   localparam int EW = 8;
   localparam int AW = 10;
   localparam int DW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [2:0]    op = '0;
   logic [AW-1:0] a_addr = '0, b_addr = '0, dst_addr = '0;
   logic [DW-1:0] a_m = '0, a_n = '0, b_m = '0, b_n = '0;
   logic [EW-1:0] scalar = '0;
   logic          busy, done, mem_rd_en, mem_wr_en;
   logic [3:0]    error_code;
   logic [DW-1:0] res_m, res_n;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr;
   logic [EW-1:0] mem_rd_data = '0;
   logic [EW-1:0] mem_wr_data;

   logic signed [EW-1:0] mem [0:(1<<AW)-1];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [EW-1:0] bd_data = '0;
   int            rd_cnt = 0, wr_cnt = 0;

   int            n_vec = 0, n_err = 0;
   int            lat, rd_d, wr_d, wr0, saw_done;
   logic          busy_after;

   always #5 clk = ~clk;

   matrix_compute_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .op          (op),
      .a_addr      (a_addr),
      .b_addr      (b_addr),
      .a_m         (a_m),
      .a_n         (a_n),
      .b_m         (b_m),
      .b_n         (b_n),
      .scalar      (scalar),
      .dst_addr    (dst_addr),
      .busy        (busy),
      .done        (done),
      .error_code  (error_code),
      .res_m       (res_m),
      .res_n       (res_n),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data)
   );

   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= mem[mem_rd_addr];
         rd_cnt      <= rd_cnt + 1;
      end
      if (mem_wr_en) begin
         mem[mem_wr_addr] <= mem_wr_data;
         wr_cnt           <= wr_cnt + 1;
      end
      if (bd_we) mem[bd_addr] <= bd_data;
   end

   task automatic check_eq(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic load(input int addr, input int val);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = AW'(addr);
      bd_data = EW'(val);
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   // restart_at > 0 pulses a second (ignorable) start at that cycle count
   task automatic run_op(input int o, input int aa, input int ba, input int am, input int an,
                         input int bm, input int bn, input int sc, input int da,
                         input int restart_at);
      int rd0, w0;
      @(negedge clk);
      op = 3'(o); a_addr = AW'(aa); b_addr = AW'(ba); dst_addr = AW'(da);
      a_m = DW'(am); a_n = DW'(an); b_m = DW'(bm); b_n = DW'(bn); scalar = EW'(sc);
      start = 1'b1;
      rd0 = rd_cnt;
      w0  = wr_cnt;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 400) begin
         if (lat == restart_at) begin
            start = 1'b1; op = 3'd2; dst_addr = 10'd300;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check_eq("done_seen", done, 1);
      rd_d = rd_cnt - rd0;
      wr_d = wr_cnt - w0;
      @(negedge clk);
      busy_after = busy;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Operand images
      for (int i = 0; i < 4; i++) begin
         load(i, i + 1);
         load(16 + i, i + 5);
         load(240 + i, 85);
      end
      for (int i = 0; i < 6; i++) begin
         load(64 + i, i + 1);
         load(80 + i, i + 7);
      end
      load(144, -3);  load(145, 100);
      load(150, -100); load(151, 10); load(154, 100); load(155, -20);
      load(176, 1);   load(177, 2);   load(192, 10);  load(193, 20);
      load(208, 85);  load(300, 85);

      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", error_code, 0);
      check_eq("rst_rd_en", mem_rd_en, 0);
      check_eq("rst_wr_en", mem_wr_en, 0);
      check_eq("rst_res_m", res_m, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD 2x2
      run_op(0, 0, 16, 2, 2, 2, 2, 0, 32, 0);
      check_eq("add_lat", lat, 18);
      check_eq("add_err", error_code, 0);
      check_eq("add_res_m", res_m, 2);
      check_eq("add_res_n", res_n, 2);
      check_eq("add_rd", rd_d, 8);
      check_eq("add_wr", wr_d, 4);
      check_eq("add_busy_after", busy_after, 0);
      check_eq("add0", mem[32], 6);  check_eq("add1", mem[33], 8);
      check_eq("add2", mem[34], 10); check_eq("add3", mem[35], 12);

      // MUL 2x3 * 3x2, lower row saturates at EW=8
      run_op(2, 64, 80, 2, 3, 3, 2, 0, 96, 0);
      check_eq("mul_lat", lat, 42);
      check_eq("mul_err", error_code, 0);
      check_eq("mul_res_n", res_n, 2);
      check_eq("mul_rd", rd_d, 24);
      check_eq("mul0", mem[96], 58);  check_eq("mul1", mem[97], 64);
      check_eq("mul2", mem[98], 127); check_eq("mul3", mem[99], 127);

      // TRANSPOSE 2x3, B dims left at 0
      run_op(3, 64, 0, 2, 3, 0, 0, 0, 128, 0);
      check_eq("tr_lat", lat, 26);
      check_eq("tr_err", error_code, 0);
      check_eq("tr_res_m", res_m, 3);
      check_eq("tr_res_n", res_n, 2);
      check_eq("tr_rd", rd_d, 6);
      check_eq("tr0", mem[128], 1); check_eq("tr1", mem[129], 4);
      check_eq("tr2", mem[130], 2); check_eq("tr3", mem[131], 5);
      check_eq("tr4", mem[132], 3); check_eq("tr5", mem[133], 6);

      // SCALAR [-3,100]*2
      run_op(4, 144, 0, 1, 2, 0, 0, 2, 160, 0);
      check_eq("sc_lat", lat, 10);
      check_eq("sc0", mem[160], -6);
      check_eq("sc1", mem[161], 127);

      // SUB with negative saturation
      run_op(1, 150, 154, 1, 2, 1, 2, 0, 170, 0);
      check_eq("sub0", mem[170], -128);
      check_eq("sub1", mem[171], 30);

      // ADD in place (dst == a_addr)
      run_op(0, 176, 192, 1, 2, 1, 2, 0, 176, 0);
      check_eq("alias0", mem[176], 11);
      check_eq("alias1", mem[177], 22);

      // Second start mid-op is ignored
      run_op(0, 0, 16, 2, 2, 2, 2, 0, 224, 4);
      check_eq("rs_lat", lat, 18);
      check_eq("rs0", mem[224], 6);
      check_eq("rs3", mem[227], 12);
      check_eq("rs_untouched", mem[300], 85);

      // Error paths
      run_op(0, 0, 16, 2, 2, 2, 3, 0, 400, 0);
      check_eq("mm_lat", lat, 2);
      check_eq("mm_err", error_code, 1);
      check_eq("mm_rd", rd_d, 0);
      check_eq("mm_wr", wr_d, 0);
      run_op(6, 0, 16, 2, 2, 2, 2, 0, 400, 0);
      check_eq("iop_lat", lat, 2);
      check_eq("iop_err", error_code, 2);
      run_op(0, 0, 16, 0, 2, 2, 2, 0, 400, 0);
      check_eq("dim0_err", error_code, 3);
      check_eq("dim0_rd", rd_d, 0);
      run_op(2, 64, 80, 2, 3, 2, 2, 0, 400, 0);
      check_eq("mulmm_err", error_code, 1);
      run_op(4, 144, 0, 1, 6, 0, 0, 2, 400, 0);
      check_eq("dimbig_err", error_code, 3);
      check_eq("dimbig_wr", wr_d, 0);

      // start and abort together in idle: not accepted
      @(negedge clk);
      op = 3'd0; a_m = 3'd2; a_n = 3'd2; b_m = 3'd2; b_n = 3'd2;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_eq("sa_busy", busy, 0);

      // Abort during MUL at k=1
      @(negedge clk);
      op = 3'd2; a_addr = 10'd64; b_addr = 10'd80; dst_addr = 10'd208;
      a_m = 3'd2; a_n = 3'd3; b_m = 3'd3; b_n = 3'd2;
      start = 1'b1;
      wr0 = wr_cnt;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("ab_pre_rd", mem_rd_en, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("ab_busy", busy, 0);
      check_eq("ab_rd_en", mem_rd_en, 0);
      check_eq("ab_wr_en", mem_wr_en, 0);
      saw_done = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      check_eq("ab_no_done", saw_done, 0);
      check_eq("ab_no_wr", wr_cnt - wr0, 0);
      check_eq("ab_dst", mem[208], 85);

      // Async reset during the first write of an ADD
      @(negedge clk);
      op = 3'd0; a_addr = 10'd0; b_addr = 10'd16; dst_addr = 10'd240;
      a_m = 3'd2; a_n = 3'd2; b_m = 3'd2; b_n = 3'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("rw_wr_en", mem_wr_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rw_busy", busy, 0);
      check_eq("rw_wr_en0", mem_wr_en, 0);
      check_eq("rw_wr_data", mem_wr_data, 0);
      check_eq("rw_wr_addr", mem_wr_addr, 0);
      check_eq("rw_rd_en", mem_rd_en, 0);
      @(negedge clk);
      check_eq("rw_dropped", mem[240], 85);
      rst_n = 1'b1;
      run_op(0, 0, 16, 2, 2, 2, 2, 0, 240, 0);
      check_eq("rw_lat", lat, 18);
      check_eq("rw_err", error_code, 0);
      check_eq("rw0", mem[240], 6);  check_eq("rw1", mem[241], 8);
      check_eq("rw2", mem[242], 10); check_eq("rw3", mem[243], 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
